icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SETS, default 16, number of direct-mapped lines; power of two, 2..256.
REQ-002 LINE_BITS, default 256, line width; 8 words of 32 bits.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 imem_read  input  1  fetch request; held high while the fetch stage waits.
REQ-006 imem_address  input  32  fetch byte address; bits [1:0] are ignored.
REQ-007 imem_resp  output  1  fetch data valid this cycle.
REQ-008 imem_rdata  output  32  instruction word for imem_address.
REQ-009 pmem_read  output  1  line-fill request to physical memory.
REQ-010 pmem_address  output  32  line-aligned fill address; bits [4:0] are zero.
REQ-011 pmem_resp  input  1  single-cycle fill completion strobe.
REQ-012 pmem_rdata  input  LINE_BITS  fill line data; valid only when pmem_resp=1.
REQ-013 miss_count  output  32  count of misses since reset.

Function
REQ-014 Address split: offset [4:0]; word select [4:2]; index [4+log2(SETS):5]; tag = all remaining upper bits.
REQ-015 Hit condition: imem_read=1, valid[index]=1, tag[index]=request tag, and FSM in IDLE.
REQ-016 On a hit, imem_resp=1 and imem_rdata=data[index] word[word select] in the same cycle (combinational, zero-wait).
REQ-017 When imem_read=0, imem_resp=0 and no fill starts.
REQ-018 When imem_resp=0, imem_rdata is don't-care; the bench does not check it.
REQ-019 FSM states: IDLE and FILL.
REQ-020 IDLE -> FILL on a miss. At that edge: latch fill_addr = {imem_address[31:5], 5'b0}; increment miss_count by 1.
REQ-021 In FILL: pmem_read=1; pmem_address=fill_addr; imem_resp=0.
REQ-022 pmem_read stays high and pmem_address stays stable until pmem_resp=1.
REQ-023 FILL -> IDLE on pmem_resp=1. At that edge: data[fill index] <= pmem_rdata; tag <= fill tag; valid <= 1.
REQ-024 Miss penalty: the hit for the same address occurs in the first IDLE cycle after pmem_resp.
REQ-025 imem_address may change during FILL (e.g. mispredict redirect). The fill still completes for the latched address. The new address is evaluated in IDLE afterward and may miss again.
REQ-026 A fill overwrites the resident line at its index unconditionally; there is no writeback (read-only cache).
REQ-027 pmem_resp while in IDLE is ignored.
REQ-028 miss_count wraps from 32'hFFFFFFFF to 0.
REQ-029 Word select 7 (offset 0x1C) returns line bits [255:224]; word 0 returns bits [31:0].

Reset
REQ-030 On rst: FSM <= IDLE; all valid bits <= 0; miss_count <= 0.
REQ-031 During and after the rst cycle: imem_resp=0 and pmem_read=0.
REQ-032 Tag and data arrays are not reset.
REQ-033 Reset during FILL abandons the fill: pmem_read=0 in the cycle after rst is sampled, and no line is installed even if pmem_resp=1 in the same cycle.
REQ-034 Any pmem_resp arriving after a reset is ignored under REQ-027.

Structure
REQ-035 A shared package cache_types holds:
 - SETS and LINE_BITS defaults;
 - offset/index/tag width constants;
 - the FSM state enum icache_state_t.
REQ-036 rv32i_word from rv32i_types is used for all 32-bit ports.
REQ-037 One sub-module, icache_array, holds valid/tag/data storage. It has a combinational read port and one synchronous write port with a write-enable.
REQ-038 Control FSM, address decode, and miss_count reside in icache.

Verification
REQ-039 Cold miss: after reset, imem_read=1, addr=0x40000000 -> next cycle pmem_read=1, pmem_address=0x40000000; return pmem_resp with line word0=0x00000013 -> next cycle imem_resp=1, imem_rdata=0x00000013, miss_count=1.
REQ-040 Sequential hits: after REQ-039, addresses 0x40000004..0x4000001C on consecutive cycles -> imem_resp=1 every cycle, words 1..7 returned, pmem_read stays 0.
REQ-041 Conflict: fill 0x40000000, then request 0x40000200 (same index, different tag) -> miss with pmem_address=0x40000200; a later 0x40000000 misses again; miss_count=3.
REQ-042 Redirect mid-fill: miss on 0x40000020; change addr to 0x40000100 before pmem_resp -> pmem_address stays 0x40000020 until resp; then miss to 0x40000100.
REQ-043 Reset mid-fill: rst during FILL coincident with pmem_resp -> pmem_read=0 next cycle; the same address misses again after reset; miss_count restarts from 0.
REQ-044 Idle: imem_read=0 for 10 cycles with valid-mismatched addresses -> imem_resp=0, pmem_read=0, miss_count unchanged.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared word type plus cache geometry, widths and FSM state enum
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage : rv32i_types

package cache_types;
  localparam int SETS_DEFAULT      = 16;
  localparam int LINE_BITS_DEFAULT = 256;
  localparam int WORD_BITS         = 32;
  localparam int OFFSET_BITS       = 5;
  localparam int WORD_SEL_BITS     = 3;
  localparam int INDEX_BITS_DEFAULT = $clog2(SETS_DEFAULT);
  localparam int TAG_BITS_DEFAULT   = 32 - OFFSET_BITS - INDEX_BITS_DEFAULT;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;
endpackage : cache_types

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and line-fill bus bundle between core, cache and memory
interface icache_if #(
  parameter int LINE_BITS = cache_types::LINE_BITS_DEFAULT
);
  logic                  imem_read;
  rv32i_types::rv32i_word imem_address;
  logic                  imem_resp;
  rv32i_types::rv32i_word imem_rdata;
  logic                  pmem_read;
  rv32i_types::rv32i_word pmem_address;
  logic                  pmem_resp;
  logic [LINE_BITS-1:0]  pmem_rdata;

  modport master (
    output imem_read, imem_address, pmem_resp, pmem_rdata,
    input  imem_resp, imem_rdata, pmem_read, pmem_address
  );

  modport slave (
    input  imem_read, imem_address, pmem_resp, pmem_rdata,
    output imem_resp, imem_rdata, pmem_read, pmem_address
  );
endinterface : icache_if

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped valid/tag/line storage, async read, one sync write port
module icache_array #(
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int TAG_W     = 23,
  localparam int IDX_W    = $clog2(SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     rd_index,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_index,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_line
);
  logic [SETS-1:0]      valid_q;
  logic [TAG_W-1:0]     tags  [SETS];
  logic [LINE_BITS-1:0] lines [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data carry no reset; a cleared valid bit hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];
endmodule : icache_array

// File: rtl/icache.sv
// rtl/icache.sv - read-only direct-mapped instruction cache with single-line fill FSM
module icache
  import cache_types::*;
  import rv32i_types::*;
#(
  parameter int SETS      = SETS_DEFAULT,
  parameter int LINE_BITS = LINE_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  icache_if.slave    bus,
  output rv32i_word  miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - OFFSET_BITS - IDX_W;

  icache_state_t state_q, state_d;

  rv32i_word                 addr;
  logic [IDX_W-1:0]          req_index;
  logic [TAG_W-1:0]          req_tag;
  logic [WORD_SEL_BITS-1:0]  word_sel;
  logic [31-OFFSET_BITS:0]   fill_line_q;
  logic [IDX_W-1:0]          fill_index;
  logic [TAG_W-1:0]          fill_tag;
  logic                      rd_valid;
  logic [TAG_W-1:0]          rd_tag;
  logic [LINE_BITS-1:0]      rd_line;
  logic                      tag_match;
  logic                      hit;
  logic                      miss_start;
  logic                      install;
  rv32i_word                 miss_count_q;
  logic                      unused_byte_bits;

  assign addr       = bus.imem_address;
  assign req_index  = addr[OFFSET_BITS +: IDX_W];
  assign req_tag    = addr[31 -: TAG_W];
  assign word_sel   = addr[OFFSET_BITS-1:2];
  assign fill_index = fill_line_q[IDX_W-1:0];
  assign fill_tag   = fill_line_q[31-OFFSET_BITS -: TAG_W];
  assign unused_byte_bits = &{1'b0, addr[1:0]};

  assign tag_match  = rd_valid && (rd_tag == req_tag);
  assign hit        = bus.imem_read && (state_q == IDLE) && tag_match && !rst;
  assign miss_start = bus.imem_read && (state_q == IDLE) && !tag_match;
  // Gating on rst drops a fill whose response lands in the reset cycle.
  assign install    = (state_q == FILL) && bus.pmem_resp && !rst;

  icache_array #(
    .SETS      (SETS),
    .LINE_BITS (LINE_BITS),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (install),
    .wr_index (fill_index),
    .wr_tag   (fill_tag),
    .wr_line  (bus.pmem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_start)    state_d = FILL;
      FILL:    if (bus.pmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_resp    = hit;
    bus.imem_rdata   = rd_line[{word_sel, 5'b00000} +: 32];
    bus.pmem_read    = (state_q == FILL) && !rst;
    bus.pmem_address = {fill_line_q, {OFFSET_BITS{1'b0}}};
  end

  // The fill address is captured once so a redirect mid-fill cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst && miss_start) begin
      fill_line_q <= addr[31:OFFSET_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count_q <= '0;
    end else if (miss_start) begin
      miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign miss_count = miss_count_q;
endmodule : icache

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] miss_count;
  int          total = 0;
  int          bad   = 0;

  icache_if #(.LINE_BITS(256)) bus ();

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] make_line(input logic [31:0] seed);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = seed + i;
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [255:0] line);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line;
    step();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_read    = 1'b1;
    bus.imem_address = 32'h4000_0000;
    bus.pmem_resp    = 1'b0;
    bus.pmem_rdata   = '0;
    step();
    chk("rst_resp", {31'b0, bus.imem_resp}, 32'd0);
    chk("rst_pread", {31'b0, bus.pmem_read}, 32'd0);
    chk("rst_mc", miss_count, 32'd0);
    step();
    chk("rst_mc_hold", miss_count, 32'd0);

    // cold miss
    rst = 1'b0;
    #1;
    chk("cold_resp", {31'b0, bus.imem_resp}, 32'd0);
    step();
    chk("cold_pread", {31'b0, bus.pmem_read}, 32'd1);
    chk("cold_paddr", bus.pmem_address, 32'h4000_0000);
    chk("cold_mc", miss_count, 32'd1);
    step();
    chk("cold_pread_hold", {31'b0, bus.pmem_read}, 32'd1);
    chk("cold_paddr_hold", bus.pmem_address, 32'h4000_0000);
    chk("cold_resp_fill", {31'b0, bus.imem_resp}, 32'd0);
    fill(make_line(32'h0000_0013));
    chk("cold_hit_resp", {31'b0, bus.imem_resp}, 32'd1);
    chk("cold_hit_data", bus.imem_rdata, 32'h0000_0013);
    chk("cold_hit_mc", miss_count, 32'd1);
    chk("cold_hit_pread", {31'b0, bus.pmem_read}, 32'd0);

    // sequential hits, words 1..7
    for (int i = 1; i < 8; i++) begin
      step();
      bus.imem_address = 32'h4000_0000 + 32'(i * 4);
      #1;
      chk("seq_resp", {31'b0, bus.imem_resp}, 32'd1);
      chk("seq_data", bus.imem_rdata, 32'h0000_0013 + 32'(i));
      chk("seq_pread", {31'b0, bus.pmem_read}, 32'd0);
    end
    bus.imem_address = 32'h4000_0007;
    #1;
    chk("byte_ignored", bus.imem_rdata, 32'h0000_0014);
    step();
    chk("seq_mc", miss_count, 32'd1);

    // conflict on index 0
    bus.imem_address = 32'h4000_0200;
    #1;
    chk("conf_resp", {31'b0, bus.imem_resp}, 32'd0);
    step();
    chk("conf_paddr", bus.pmem_address, 32'h4000_0200);
    chk("conf_mc", miss_count, 32'd2);
    fill(make_line(32'h0000_0200));
    chk("conf_hit", bus.imem_rdata, 32'h0000_0200);
    chk("conf_hit_resp", {31'b0, bus.imem_resp}, 32'd1);
    bus.imem_address = 32'h4000_0000;
    #1;
    chk("conf_back_resp", {31'b0, bus.imem_resp}, 32'd0);
    step();
    chk("conf_back_paddr", bus.pmem_address, 32'h4000_0000);
    chk("conf_back_mc", miss_count, 32'd3);
    fill(make_line(32'h0000_0013));
    chk("conf_back_hit", bus.imem_rdata, 32'h0000_0013);

    // redirect mid-fill
    bus.imem_address = 32'h4000_0020;
    #1;
    chk("redir_resp0", {31'b0, bus.imem_resp}, 32'd0);
    step();
    chk("redir_paddr0", bus.pmem_address, 32'h4000_0020);
    chk("redir_mc0", miss_count, 32'd4);
    bus.imem_address = 32'h4000_0100;
    step();
    chk("redir_paddr_hold", bus.pmem_address, 32'h4000_0020);
    chk("redir_pread_hold", {31'b0, bus.pmem_read}, 32'd1);
    chk("redir_resp_fill", {31'b0, bus.imem_resp}, 32'd0);
    fill(make_line(32'h0000_0500));
    chk("redir_new_miss", {31'b0, bus.imem_resp}, 32'd0);
    step();
    chk("redir_paddr1", bus.pmem_address, 32'h4000_0100);
    chk("redir_mc1", miss_count, 32'd5);
    fill(make_line(32'h0000_0600));
    chk("redir_hit1", bus.imem_rdata, 32'h0000_0600);
    bus.imem_address = 32'h4000_0020;
    #1;
    chk("redir_latched_hit", bus.imem_rdata, 32'h0000_0500);
    bus.imem_address = 32'h4000_003C;
    #1;
    chk("word7", bus.imem_rdata, 32'h0000_0507);
    chk("word7_resp", {31'b0, bus.imem_resp}, 32'd1);

    // idle with stray pmem_resp
    bus.imem_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.imem_address = 32'h5000_0000 + 32'(i * 32);
      bus.pmem_resp    = i[0];
      bus.pmem_rdata   = make_line(32'hDEAD_0000);
      #1;
      chk("idle_resp", {31'b0, bus.imem_resp}, 32'd0);
      chk("idle_pread", {31'b0, bus.pmem_read}, 32'd0);
      step();
    end
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    chk("idle_mc", miss_count, 32'd5);
    bus.imem_read    = 1'b1;
    bus.imem_address = 32'h4000_0000;
    #1;
    chk("idle_after_hit", bus.imem_rdata, 32'h0000_0013);
    chk("idle_after_resp", {31'b0, bus.imem_resp}, 32'd1);

    // reset mid-fill with coincident pmem_resp
    bus.imem_address = 32'h4000_0400;
    step();
    chk("rfill_pread", {31'b0, bus.pmem_read}, 32'd1);
    chk("rfill_mc", miss_count, 32'd6);
    rst            = 1'b1;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = make_line(32'h0000_0700);
    #1;
    chk("rfill_pread_rst", {31'b0, bus.pmem_read}, 32'd0);
    step();
    rst            = 1'b0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    #1;
    chk("rfill_pread_after", {31'b0, bus.pmem_read}, 32'd0);
    chk("rfill_resp_after", {31'b0, bus.imem_resp}, 32'd0);
    chk("rfill_mc_zero", miss_count, 32'd0);
    step();
    chk("rfill_remiss_pread", {31'b0, bus.pmem_read}, 32'd1);
    chk("rfill_remiss_paddr", bus.pmem_address, 32'h4000_0400);
    chk("rfill_remiss_mc", miss_count, 32'd1);
    fill(make_line(32'h0000_0800));
    chk("rfill_hit", bus.imem_rdata, 32'h0000_0800);
    chk("rfill_hit_resp", {31'b0, bus.imem_resp}, 32'd1);
    bus.imem_address = 32'h4000_0000;
    #1;
    chk("post_rst_cold", {31'b0, bus.imem_resp}, 32'd0);
    bus.imem_read = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule : tb_icache
